// File: rtl/jtkcpu_stkseq.sv
// Stack transfer sequencer for PSHS/PSHU/PULS/PULU: walks a register mask and
// runs one byte-wide bus cycle per register byte, issuing register loads on pulls.
module jtkcpu_stkseq #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          psh_go,
    input  logic          pul_go,
    input  logic [7:0]    mask,
    input  logic [AW-1:0] sp_in,
    input  logic [15:0]   pc,
    input  logic [15:0]   alt,
    input  logic [15:0]   y,
    input  logic [15:0]   x,
    input  logic [7:0]    dp,
    input  logic [7:0]    b,
    input  logic [7:0]    a,
    input  logic [7:0]    cc,
    input  logic          bus_ack,
    input  logic [7:0]    din,
    output logic          busy,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] addr,
    output logic [7:0]    dout,
    output logic          ld,
    output logic [7:0]    ld_sel,
    output logic [15:0]   ld_data,
    output logic [AW-1:0] sp_out,
    output logic          sp_we,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;

    localparam logic [AW-1:0] SP_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [7:0]    mask_q, mask_d;
    logic [AW-1:0] sp_q, sp_d;
    logic          push_q, push_d;
    logic          second_q, second_d;
    logic [7:0]    hold_q, hold_d;
    logic          ld_q, ld_d;
    logic [7:0]    ld_sel_q, ld_sel_d;
    logic [15:0]   ld_data_q, ld_data_d;

    logic [7:0]    top_oh, low_oh, sel;
    logic          is16, last_byte;
    logic [15:0]   word_val;
    logic [7:0]    byte_val, push_byte;

    // Push services registers from b7 down, pull from b0 up.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_top
            if (gi == 7) begin : g_msb
                assign top_oh[gi] = mask_q[gi];
            end else begin : g_rest
                assign top_oh[gi] = mask_q[gi] & ~(|mask_q[7:gi+1]);
            end
        end
    endgenerate

    assign low_oh    = mask_q & (~mask_q + 8'd1);
    assign sel       = push_q ? top_oh : low_oh;
    assign is16      = |sel[7:4];
    assign last_byte = ~is16 | second_q;

    assign word_val  = ({16{sel[7]}} & pc) | ({16{sel[6]}} & alt)
                     | ({16{sel[5]}} & y)  | ({16{sel[4]}} & x);
    assign byte_val  = ({8{sel[3]}} & dp) | ({8{sel[2]}} & b)
                     | ({8{sel[1]}} & a)  | ({8{sel[0]}} & cc);
    // 16-bit pushes go low byte first so the high byte ends up at the lower address.
    assign push_byte = is16 ? (second_q ? word_val[15:8] : word_val[7:0]) : byte_val;

    assign busy    = (state_q != IDLE);
    assign bus_req = (state_q == XFER);
    assign bus_we  = (state_q == XFER) & push_q;
    assign addr    = (state_q == XFER) ? (push_q ? sp_q - SP_ONE : sp_q) : '0;
    assign dout    = ((state_q == XFER) & push_q) ? push_byte : 8'h00;
    assign ld      = ld_q;
    assign ld_sel  = ld_sel_q;
    assign ld_data = ld_data_q;
    assign sp_out  = sp_q;
    assign sp_we   = (state_q == FIN);
    assign done    = (state_q == FIN);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        sp_d      = sp_q;
        push_d    = push_q;
        second_d  = second_q;
        hold_d    = hold_q;
        ld_d      = 1'b0;
        ld_sel_d  = ld_sel_q;
        ld_data_d = ld_data_q;
        case (state_q)
            IDLE: begin
                if (psh_go || pul_go) begin
                    mask_d   = mask;
                    sp_d     = sp_in;
                    push_d   = psh_go;
                    second_d = 1'b0;
                    state_d  = (mask == 8'h00) ? FIN : XFER;
                end
            end
            XFER: begin
                if (bus_ack) begin
                    sp_d = push_q ? sp_q - SP_ONE : sp_q + SP_ONE;
                    if (!push_q && !second_q) begin
                        hold_d = din;
                    end
                    if (last_byte) begin
                        mask_d   = mask_q & ~sel;
                        second_d = 1'b0;
                        if (!push_q) begin
                            ld_d      = 1'b1;
                            ld_sel_d  = sel;
                            ld_data_d = is16 ? {hold_q, din} : {8'h00, din};
                        end
                        if ((mask_q & ~sel) == 8'h00) begin
                            state_d = FIN;
                        end
                    end else begin
                        second_d = 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= 8'h00;
            sp_q      <= '0;
            push_q    <= 1'b0;
            second_q  <= 1'b0;
            hold_q    <= 8'h00;
            ld_q      <= 1'b0;
            ld_sel_q  <= 8'h00;
            ld_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            sp_q      <= sp_d;
            push_q    <= push_d;
            second_q  <= second_d;
            hold_q    <= hold_d;
            ld_q      <= ld_d;
            ld_sel_q  <= ld_sel_d;
            ld_data_q <= ld_data_d;
        end
    end
endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Bench for jtkcpu_stkseq: a memory/bus slave with programmable wait states plus
// a byte-list reference model of stack push/pull order and pointer arithmetic.
module tb_jtkcpu_stkseq;
    logic        clk = 1'b0, rst = 1'b1, psh_go = 1'b0, pul_go = 1'b0;
    logic [7:0]  mask = 8'h00;
    logic [15:0] sp_in = 16'h0000;
    logic [15:0] pc = 0, alt = 0, y = 0, x = 0;
    logic [7:0]  dp = 0, b = 0, a = 0, cc = 0;
    logic        bus_ack = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        busy, bus_req, bus_we, ld, sp_we, done;
    logic [15:0] addr, ld_data, sp_out;
    logic [7:0]  dout, ld_sel;

    jtkcpu_stkseq #(.AW(16)) dut (
        .clk(clk), .rst(rst), .psh_go(psh_go), .pul_go(pul_go), .mask(mask),
        .sp_in(sp_in), .pc(pc), .alt(alt), .y(y), .x(x), .dp(dp), .b(b), .a(a),
        .cc(cc), .bus_ack(bus_ack), .din(din), .busy(busy), .bus_req(bus_req),
        .bus_we(bus_we), .addr(addr), .dout(dout), .ld(ld), .ld_sel(ld_sel),
        .ld_data(ld_data), .sp_out(sp_out), .sp_we(sp_we), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  mem [0:65535];
    logic [23:0] wq[$];
    logic [23:0] ldq[$];
    int wait_n = 0, wcnt = 0, req_cycles = 0, hold_viol = 0, spwe_viol = 0;
    int done_cnt = 0, done_cyc = 0;
    logic [15:0] done_sp = 0, p_addr = 0;
    logic [7:0]  p_dout = 0;
    logic        p_we = 0, prev_wait = 0;
    int checks = 0, errors = 0;

    // Bus slave and monitor: decisions are made on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bus_ack = 1'b0; wcnt = 0; prev_wait = 1'b0;
            end else begin
                if (prev_wait && (bus_req !== 1'b1 || addr !== p_addr ||
                                  dout !== p_dout || bus_we !== p_we))
                    hold_viol++;
                if (bus_req === 1'b1) begin
                    req_cycles++;
                    if (wcnt >= wait_n) begin
                        bus_ack = 1'b1; wcnt = 0; prev_wait = 1'b0;
                        if (bus_we) begin
                            mem[addr] = dout;
                            wq.push_back({addr, dout});
                        end else begin
                            din = mem[addr];
                        end
                    end else begin
                        bus_ack = 1'b0; wcnt++; prev_wait = 1'b1;
                        p_addr = addr; p_dout = dout; p_we = bus_we;
                    end
                end else begin
                    bus_ack = 1'b0; wcnt = 0; prev_wait = 1'b0;
                end
                if (ld === 1'b1) ldq.push_back({ld_sel, ld_data});
                if (sp_we !== done) spwe_viol++;
                if (done === 1'b1) begin
                    done_cnt++; done_cyc = cyc; done_sp = sp_out;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input bit push, input bit both, input logic [7:0] m,
                           input logic [15:0] sp0, input int w, input bit hold);
        logic [15:0] v16 [4];
        logic [7:0]  v8 [4];
        logic [23:0] ew[$];
        logic [23:0] el[$];
        logic [15:0] s, s1;
        int n, t0, d0, k;
        for (int i = 0; i < 4; i++) begin
            v16[i] = 16'($urandom); v8[i] = 8'($urandom);
        end
        pc = v16[3]; alt = v16[2]; y = v16[1]; x = v16[0];
        dp = v8[3];  b = v8[2];    a = v8[1];  cc = v8[0];
        s = sp0; n = 0;
        if (push) begin
            for (int bi = 7; bi >= 0; bi--) begin
                if (m[bi]) begin
                    if (bi >= 4) begin
                        s = s - 16'd1; ew.push_back({s, v16[bi-4][7:0]});
                        s = s - 16'd1; ew.push_back({s, v16[bi-4][15:8]});
                        n += 2;
                    end else begin
                        s = s - 16'd1; ew.push_back({s, v8[bi]});
                        n += 1;
                    end
                end
            end
        end else begin
            for (int bi = 0; bi < 8; bi++) begin
                if (m[bi]) begin
                    s1 = s + 16'd1;
                    if (bi >= 4) begin
                        el.push_back({8'(1 << bi), mem[s], mem[s1]});
                        s = s + 16'd2; n += 2;
                    end else begin
                        el.push_back({8'(1 << bi), 8'h00, mem[s]});
                        s = s1; n += 1;
                    end
                end
            end
        end
        $display("seq push=%0d both=%0d mask=%h sp=%h wait=%0d hold=%0d bytes=%0d",
                 push, both, m, sp0, w, hold, n);
        wq.delete(); ldq.delete();
        req_cycles = 0; hold_viol = 0; spwe_viol = 0; wait_n = w; d0 = done_cnt;
        @(negedge clk);
        mask = m; sp_in = sp0; psh_go = push; pul_go = both | ~push;
        @(posedge clk); #1;
        t0 = cyc;
        if (!hold) begin psh_go = 1'b0; pul_go = 1'b0; end
        for (k = 0; k < 400 && done_cnt == d0; k++) begin
            @(negedge clk); #1;
        end
        psh_go = 1'b0; pul_go = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
        chk("latency", done_cyc - t0, n * (w + 1));
        chk("sp_out", {16'h0, done_sp}, {16'h0, s});
        chk("req_cycles", req_cycles, n * (w + 1));
        chk("hold_stable", hold_viol, 0);
        chk("spwe_eq_done", spwe_viol, 0);
        chk("write_count", wq.size(), ew.size());
        for (int i = 0; i < ew.size() && i < wq.size(); i++)
            chk($sformatf("write%0d", i), {8'h0, wq[i]}, {8'h0, ew[i]});
        chk("ld_count", ldq.size(), el.size());
        for (int i = 0; i < el.size() && i < ldq.size(); i++)
            chk($sformatf("ld%0d", i), {8'h0, ldq[i]}, {8'h0, el[i]});
        @(posedge clk); #1;
        chk("idle_after", {31'h0, busy}, 0);
    endtask

    initial begin
        int d0, k;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_bus_req", {31'h0, bus_req}, 0);
        chk("rst_bus_we", {31'h0, bus_we}, 0);
        chk("rst_addr", {16'h0, addr}, 0);
        chk("rst_dout", {24'h0, dout}, 0);
        chk("rst_ld", {31'h0, ld}, 0);
        chk("rst_ld_sel", {24'h0, ld_sel}, 0);
        chk("rst_ld_data", {16'h0, ld_data}, 0);
        chk("rst_sp_out", {16'h0, sp_out}, 0);
        chk("rst_sp_we", {31'h0, sp_we}, 0);
        chk("rst_done", {31'h0, done}, 0);
        @(negedge clk); rst = 1'b0;

        run_seq(1'b1, 1'b0, 8'hFF, 16'h1000, 0, 1'b0);
        mem[16'h0FF0] = 8'h12; mem[16'h0FF1] = 8'h34;
        run_seq(1'b0, 1'b0, 8'h06, 16'h0FF0, 0, 1'b0);
        chk("pul_a", {8'h0, ldq[0]}, 32'h00020012);
        chk("pul_b", {8'h0, ldq[1]}, 32'h00040034);
        chk("pul_sp", {16'h0, done_sp}, 32'h0FF2);
        mem[16'h2000] = 8'hAB; mem[16'h2001] = 8'hCD;
        run_seq(1'b0, 1'b0, 8'h10, 16'h2000, 0, 1'b0);
        chk("pulu_x", {8'h0, ldq[0]}, 32'h0010ABCD);
        run_seq(1'b1, 1'b0, 8'h00, 16'h1234, 0, 1'b0);
        chk("empty_sp", {16'h0, done_sp}, 32'h1234);
        run_seq(1'b1, 1'b0, 8'h02, 16'h0800, 3, 1'b0);
        run_seq(1'b1, 1'b0, 8'h01, 16'h0000, 0, 1'b0);
        run_seq(1'b0, 1'b0, 8'h10, 16'hFFFF, 1, 1'b0);
        run_seq(1'b1, 1'b1, 8'h95, 16'h4000, 0, 1'b1);

        // Abort a push during its third byte.
        wait_n = 0; d0 = done_cnt; wq.delete();
        @(negedge clk); mask = 8'hFF; sp_in = 16'h3000; psh_go = 1'b1;
        @(posedge clk); #1; psh_go = 1'b0;
        for (k = 0; k < 50 && wq.size() < 2; k++) begin
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        chk("abort_req3", {31'h0, bus_req}, 1);
        chk("abort_addr3", {16'h0, addr}, 32'h2FFD);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_bus_req", {31'h0, bus_req}, 0);
        chk("abort_sp_we", {31'h0, sp_we}, 0);
        chk("abort_ld", {31'h0, ld}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        run_seq(1'b1, 1'b0, 8'hFF, 16'h3000, 0, 1'b0);

        for (int r = 0; r < 16; r++)
            run_seq(1'($urandom_range(0, 1)), 1'b0, 8'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
